// File: rtl/pet_stats.sv
// pet_stats: virtual-pet status engine.
// Turns the rate divider's toggling level into game ticks, decays hunger and
// happiness on every DECAY_TICKS-th tick, applies feed/play requests over a
// req/ack handshake and reports a mood code to the renderer.
module pet_stats #(
  parameter int STAT_W      = 7,
  parameter int STAT_MAX    = 100,
  parameter int DECAY_TICKS = 4,
  parameter int FEED_AMT    = 20,
  parameter int PLAY_AMT    = 15,
  parameter int PLAY_COST   = 2,
  parameter int LOW_THRESH  = 25
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tick_wave,
  input  logic              feed_req,
  input  logic              play_req,
  output logic              feed_ack,
  output logic              play_ack,
  output logic              tick,
  output logic [STAT_W-1:0] hunger,
  output logic [STAT_W-1:0] happiness,
  output logic [1:0]        mood
);

  // One spare bit so sums can exceed STAT_MAX before being clamped.
  localparam int W  = STAT_W + 1;
  localparam int PW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

  localparam logic [W-1:0]      MAX_W    = W'(STAT_MAX);
  localparam logic [W-1:0]      FEED_W   = W'(FEED_AMT);
  localparam logic [W-1:0]      PLAY_W   = W'(PLAY_AMT);
  localparam logic [W-1:0]      COST_W   = W'(PLAY_COST);
  localparam logic [STAT_W-1:0] LOW_S    = STAT_W'(LOW_THRESH);
  localparam logic [STAT_W-1:0] INIT_S   = STAT_W'(STAT_MAX);
  localparam logic [PW-1:0]     PRE_LAST = PW'(DECAY_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef enum logic {
    OP_FEED = 1'b0,
    OP_PLAY = 1'b1
  } op_t;

  logic          prev_wave;
  logic [PW-1:0] prescaler;
  state_t        state;
  op_t           op;
  logic          dead;
  logic          decay;
  logic          apply_now;
  logic [W-1:0]  h_dec;
  logic [W-1:0]  hp_dec;
  logic [W-1:0]  h_sum;
  logic [W-1:0]  hp_sum;
  logic [W-1:0]  h_next;
  logic [W-1:0]  hp_next;

  // Both edges of the divider level count as a tick; a dead pet never decays.
  assign tick      = tick_wave ^ prev_wave;
  assign decay     = tick && (prescaler == PRE_LAST) && !dead;
  assign apply_now = (state == APPLY) && !dead;

  // Track the previous wave level and count ticks towards the next decay step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_wave <= 1'b0;
      prescaler <= '0;
    end else begin
      prev_wave <= tick_wave;
      if (tick) begin
        prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
      end
    end
  end

  // Next stat values: saturating decay first, then the pending op, clamped once.
  always_comb begin
    h_dec   = {1'b0, hunger};
    hp_dec  = {1'b0, happiness};
    h_sum   = '0;
    hp_sum  = '0;
    if (decay) begin
      if (hunger != '0) h_dec = {1'b0, hunger} - 1'b1;
      if (happiness != '0) hp_dec = {1'b0, happiness} - 1'b1;
    end
    h_next  = h_dec;
    hp_next = hp_dec;
    if (apply_now && op == OP_FEED) begin
      h_sum  = h_dec + FEED_W;
      h_next = (h_sum > MAX_W) ? MAX_W : h_sum;
    end
    if (apply_now && op == OP_PLAY) begin
      hp_sum  = hp_dec + PLAY_W;
      hp_next = (hp_sum > MAX_W) ? MAX_W : hp_sum;
      h_next  = (h_dec < COST_W) ? '0 : h_dec - COST_W;
    end
  end

  // Stat registers and the sticky dead flag, set once both stats hit zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hunger    <= INIT_S;
      happiness <= INIT_S;
      dead      <= 1'b0;
    end else begin
      hunger    <= h_next[STAT_W-1:0];
      happiness <= hp_next[STAT_W-1:0];
      dead      <= dead | ((h_next == '0) && (hp_next == '0));
    end
  end

  // Request handshake: accept, apply for one cycle, then wait for the request to drop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      op       <= OP_FEED;
      feed_ack <= 1'b0;
      play_ack <= 1'b0;
    end else begin
      feed_ack <= 1'b0;
      play_ack <= 1'b0;
      if (dead) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (feed_req) begin
              op    <= OP_FEED;
              state <= APPLY;
            end else if (play_req) begin
              op    <= OP_PLAY;
              state <= APPLY;
            end
          end
          APPLY: begin
            feed_ack <= (op == OP_FEED);
            play_ack <= (op == OP_PLAY);
            state    <= HOLD;
          end
          HOLD: begin
            if (!((op == OP_FEED) ? feed_req : play_req)) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Mood in priority order: dead, hungry, sad, happy.
  always_comb begin
    mood = 2'd0;
    if (dead) begin
      mood = 2'd3;
    end else if (hunger < LOW_S) begin
      mood = 2'd1;
    end else if (happiness < LOW_S) begin
      mood = 2'd2;
    end
  end

endmodule

// File: tb/tb_pet_stats.sv
// tb_pet_stats: scoreboard bench for pet_stats.
// The stimulus process drives one input vector per cycle, runs a behavioural
// model of the pet and pushes the expected outputs for that cycle; a monitor
// samples the DUT shortly after each falling edge and checks against the queue.
module tb_pet_stats;

  localparam int DECAY_TICKS = 4;
  localparam int STAT_MAX    = 100;
  localparam int FEED_AMT    = 20;
  localparam int PLAY_AMT    = 15;
  localparam int PLAY_COST   = 2;
  localparam int LOW_THRESH  = 25;

  logic       clk;
  logic       resetn;
  logic       tick_wave;
  logic       feed_req;
  logic       play_req;
  logic       feed_ack;
  logic       play_ack;
  logic       tick;
  logic [6:0] hunger;
  logic [6:0] happiness;
  logic [1:0] mood;

  typedef struct {
    int t;
    int fa;
    int pa;
    int h;
    int hp;
    int md;
  } snap_t;

  snap_t expQ[$];

  int checks  = 0;
  int errors  = 0;
  bit running = 0;

  // Stimulus shadow of the inputs.
  bit curWave = 0;
  bit curFeed = 0;
  bit curPlay = 0;

  // Behavioural pet model.
  int mH, mHp, mTicks, cyc;
  bit mPrev, mDead, mBusy, mOpFeed;
  int mApplyAt, mAckAt;
  bit mAckFeed;

  pet_stats dut (
    .clk       (clk),
    .resetn    (resetn),
    .tick_wave (tick_wave),
    .feed_req  (feed_req),
    .play_req  (play_req),
    .feed_ack  (feed_ack),
    .play_ack  (play_ack),
    .tick      (tick),
    .hunger    (hunger),
    .happiness (happiness),
    .mood      (mood)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Compare one field, count it, and report a failure line.
  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Reference model: expected outputs for the current cycle, then advance one clock.
  task automatic modelStep(input bit rn, input bit wave, input bit f, input bit p);
    snap_t s;
    bit    t;
    bit    dec;
    int    h;
    int    hp;
    if (!rn) begin
      mH = STAT_MAX; mHp = STAT_MAX; mTicks = 0; mPrev = 0; mDead = 0;
      mBusy = 0; mApplyAt = -1; mAckAt = -1; mAckFeed = 0;
    end
    t    = (wave != mPrev);
    s.t  = t;
    s.fa = (cyc == mAckAt && mAckFeed) ? 1 : 0;
    s.pa = (cyc == mAckAt && !mAckFeed) ? 1 : 0;
    s.h  = mH;
    s.hp = mHp;
    s.md = mDead ? 3 : (mH < LOW_THRESH) ? 1 : (mHp < LOW_THRESH) ? 2 : 0;
    expQ.push_back(s);
    if (rn) begin
      dec = 0;
      if (t) begin
        mTicks++;
        if ((mTicks % DECAY_TICKS) == 0 && !mDead) dec = 1;
      end
      h  = mH;
      hp = mHp;
      if (dec) begin
        h  = imax(h - 1, 0);
        hp = imax(hp - 1, 0);
      end
      if (cyc == mApplyAt && !mDead) begin
        if (mOpFeed) begin
          h = imin(h + FEED_AMT, STAT_MAX);
        end else begin
          hp = imin(hp + PLAY_AMT, STAT_MAX);
          h  = imax(h - PLAY_COST, 0);
        end
        mAckAt   = cyc + 1;
        mAckFeed = mOpFeed;
      end
      if (mDead) begin
        mBusy = 0;
      end else if (!mBusy) begin
        if (f || p) begin
          mBusy    = 1;
          mOpFeed  = f;
          mApplyAt = cyc + 1;
        end
      end else if (cyc > mApplyAt && !(mOpFeed ? f : p)) begin
        mBusy = 0;
      end
      if (!mDead && h == 0 && hp == 0) mDead = 1;
      mH    = h;
      mHp   = hp;
      mPrev = wave;
    end
    cyc++;
  endtask

  // Drive one cycle of inputs on the falling edge and record its expectation.
  task automatic applyStimulus(input bit rn, input bit wave, input bit f, input bit p);
    @(negedge clk);
    resetn    = rn;
    tick_wave = wave;
    feed_req  = f;
    play_req  = p;
    modelStep(rn, wave, f, p);
  endtask

  task automatic step();
    applyStimulus(1'b1, curWave, curFeed, curPlay);
  endtask

  task automatic doReset(input int n);
    curFeed = 0;
    curPlay = 0;
    repeat (n) applyStimulus(1'b0, curWave, 1'b0, 1'b0);
  endtask

  // n wave transitions, each followed by gap-1 steady cycles.
  task automatic toggles(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      curWave = ~curWave;
      step();
      repeat (gap - 1) step();
    end
  endtask

  // Raise a request, hold it for some cycles, drop it and idle one cycle.
  task automatic doReq(input bit f, input bit p, input int hold);
    curFeed = f;
    curPlay = p;
    repeat (hold) step();
    curFeed = 0;
    curPlay = 0;
    step();
  endtask

  // Monitor: pops the expectation for each cycle and compares every output.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      #1;
      if (running) begin
        if (expQ.size() == 0) begin
          checkOutput("queue_empty", 0, 1);
        end else begin
          e = expQ.pop_front();
          checkOutput("tick", int'(tick), e.t);
          checkOutput("feed_ack", int'(feed_ack), e.fa);
          checkOutput("play_ack", int'(play_ack), e.pa);
          checkOutput("hunger", int'(hunger), e.h);
          checkOutput("happiness", int'(happiness), e.hp);
          checkOutput("mood", int'(mood), e.md);
        end
      end
    end
  end

  initial begin
    resetn    = 1'b0;
    tick_wave = 1'b0;
    feed_req  = 1'b0;
    play_req  = 1'b0;
    cyc       = 0;
    modelStep(1'b0, 1'b0, 1'b0, 1'b0);
    void'(expQ.pop_front());
    running = 1;

    $display("[TB] reset and slow ticks");
    doReset(3);
    step();
    toggles(8, 5);

    $display("[TB] decay to 30 then feed twice");
    toggles(272, 1);
    step();
    doReq(1'b1, 1'b0, 10);
    doReq(1'b1, 1'b0, 4);

    $display("[TB] play clamp at hunger 1 happiness 90");
    doReset(2);
    toggles(4, 1);
    repeat (44) doReq(1'b0, 1'b1, 4);
    toggles(40, 2);
    doReq(1'b0, 1'b1, 4);
    repeat (3) step();

    $display("[TB] priority");
    doReset(2);
    curFeed = 1; curPlay = 1;
    repeat (6) step();
    curFeed = 0;
    repeat (6) step();
    curPlay = 0;
    repeat (3) step();

    $display("[TB] decay coinciding with apply");
    doReset(2);
    toggles(3, 2);
    curFeed = 1;
    step();
    curWave = ~curWave;
    step();
    repeat (3) step();
    curFeed = 0;
    repeat (2) step();

    $display("[TB] decay to death");
    doReset(2);
    toggles(400, 1);
    toggles(12, 1);
    doReq(1'b1, 1'b0, 5);
    doReq(1'b0, 1'b1, 5);

    $display("[TB] reset during hold");
    doReset(2);
    toggles(8, 1);
    curFeed = 1;
    repeat (3) step();
    repeat (2) applyStimulus(1'b0, curWave, 1'b1, 1'b0);
    repeat (5) step();
    curFeed = 0;
    repeat (2) step();

    $display("[TB] random traffic");
    doReset(2);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 0) curWave = ~curWave;
      if ($urandom_range(0, 7) == 0) curFeed = ~curFeed;
      if ($urandom_range(0, 7) == 0) curPlay = ~curPlay;
      if ($urandom_range(0, 299) == 0) begin
        applyStimulus(1'b0, curWave, curFeed, curPlay);
      end else begin
        step();
      end
    end

    @(negedge clk);
    running = 0;
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
